// File: rtl/regbank_ctrl_pkg.sv
// Shared types, opcode constants, instruction field positions and the
// instruction decode helper for the register-bank sequencer.
package regbank_ctrl_pkg;

    // Sequencer states, binary encoded in the order an instruction visits them
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        WB     = 2'b11
    } state_t;

    // Opcodes with special meaning; every other op is an immediate-form ALU op
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_NOP   = 4'b1111;
    localparam logic [3:0] OP_CMP   = 4'b1011;

    // Instruction word layout: [15:12] op, [11:8] rdest, [7:4] ext, [3:0] rsrc
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int RDEST_MSB = 11;
    localparam int RDEST_LSB = 8;
    localparam int EXT_MSB   = 7;
    localparam int EXT_LSB   = 4;
    localparam int RSRC_MSB  = 3;
    localparam int RSRC_LSB  = 0;

    // Datapath controls derived from one instruction word
    typedef struct packed {
        logic [3:0]  alu_op;
        logic        imm_sel;
        logic [15:0] imm;
        logic        writeback;
        logic        flags;
    } decode_t;

    // Register form takes its ALU function from ext; immediate form uses the
    // op itself. Compares only update flags, NOP touches nothing.
    function automatic decode_t decode_instr(input logic [15:0] ir);
        logic [3:0] op;
        logic [3:0] ext;
        logic [3:0] rsrc;
        decode_t    d;
        op   = ir[OP_MSB:OP_LSB];
        ext  = ir[EXT_MSB:EXT_LSB];
        rsrc = ir[RSRC_MSB:RSRC_LSB];
        d.imm       = {{8{ext[3]}}, ext, rsrc};
        d.alu_op    = 4'b0000;
        d.imm_sel   = 1'b0;
        d.writeback = 1'b0;
        d.flags     = 1'b0;
        if (op == OP_RTYPE) begin
            d.alu_op    = ext;
            d.flags     = 1'b1;
            d.writeback = (ext != OP_CMP);
        end else if (op != OP_NOP) begin
            d.alu_op    = op;
            d.imm_sel   = 1'b1;
            d.flags     = 1'b1;
            d.writeback = (op != OP_CMP);
        end
        return d;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// 4-to-16 one-hot register select with enable; purely combinational.
module reg_sel_decoder (
    input  logic [3:0]  i_idx,
    input  logic        i_en,
    output logic [15:0] o_onehot
);

    // One comparator per register; at most one output can be high
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            assign o_onehot[gi] = i_en && (i_idx == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/regbank_ctrl.sv
// Four-state sequencer for the 16 x 16-bit register bank and ALU.
// All datapath controls are decoded from the held instruction register, so
// they stay stable through DECODE/EXEC/WB and keep their last value in IDLE.
// Pulses (regEnable, flags_we, done) are qualified by the WB state register,
// so an asynchronous reset removes them in the same instant.
module regbank_ctrl
    import regbank_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  rsrc_sel,
    output logic [3:0]  rdest_sel,
    output logic [3:0]  alu_op,
    output logic        imm_sel,
    output logic [15:0] imm,
    output logic [15:0] regEnable,
    output logic        flags_we,
    output logic        done
);

    state_t      r_state;
    logic [15:0] r_ir;
    decode_t     w_dec;
    logic        w_wb_en;

    // Sequencer and instruction register; IR only loads on an accepted handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ir    <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_state <= DECODE;
                    end
                end
                DECODE:  r_state <= EXEC;
                EXEC:    r_state <= WB;
                WB:      r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decode of the held instruction; an all-zero IR yields all-zero controls
    always_comb begin
        w_dec = decode_instr(r_ir);
    end

    assign instr_ready = (r_state == IDLE);
    assign done        = (r_state == WB);
    assign flags_we    = (r_state == WB) && w_dec.flags;
    assign w_wb_en     = (r_state == WB) && w_dec.writeback;

    assign rdest_sel = r_ir[RDEST_MSB:RDEST_LSB];
    assign rsrc_sel  = r_ir[RSRC_MSB:RSRC_LSB];
    assign alu_op    = w_dec.alu_op;
    assign imm_sel   = w_dec.imm_sel;
    assign imm       = w_dec.imm;

    reg_sel_decoder u_reg_sel (
        .i_idx    (r_ir[RDEST_MSB:RDEST_LSB]),
        .i_en     (w_wb_en),
        .o_onehot (regEnable)
    );

endmodule

// File: tb/tb_regbank_ctrl.sv
// Self-checking bench for regbank_ctrl: directed cases then random traffic,
// compared every cycle against a transaction-level reference model.
module tb_regbank_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  rsrc_sel;
    logic [3:0]  rdest_sel;
    logic [3:0]  alu_op;
    logic        imm_sel;
    logic [15:0] imm;
    logic [15:0] regEnable;
    logic        flags_we;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the last accepted word and cycles elapsed since accept
    logic [15:0] m_word  = 16'h0000;
    int          m_phase = 0;

    regbank_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rsrc_sel    (rsrc_sel),
        .rdest_sel   (rdest_sel),
        .alu_op      (alu_op),
        .imm_sel     (imm_sel),
        .imm         (imm),
        .regEnable   (regEnable),
        .flags_we    (flags_we),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs from the instruction-set rules, using plain arithmetic
    task automatic compare_outputs();
        int op, rd, ext, rs, low8, e_alu, e_isel, e_imm, e_flags, e_wb, e_re;
        op   = int'(m_word) / 4096;
        rd   = (int'(m_word) / 256) % 16;
        ext  = (int'(m_word) / 16) % 16;
        rs   = int'(m_word) % 16;
        low8 = ext * 16 + rs;
        e_imm = (low8 >= 128) ? (low8 + 65280) : low8;
        if (op == 0) begin
            e_alu = ext; e_isel = 0; e_flags = 1; e_wb = (ext != 11);
        end else if (op == 15) begin
            e_alu = 0; e_isel = 0; e_flags = 0; e_wb = 0;
        end else begin
            e_alu = op; e_isel = 1; e_flags = 1; e_wb = (op != 11);
        end
        e_re = (m_phase == 3 && e_wb != 0) ? (1 << rd) : 0;
        check_val("instr_ready", 32'(instr_ready), 32'(m_phase == 0));
        check_val("done",        32'(done),        32'(m_phase == 3));
        check_val("flags_we",    32'(flags_we),    32'((m_phase == 3) && (e_flags != 0)));
        check_val("regEnable",   32'(regEnable),   32'(e_re));
        check_val("onehot",      32'($countones(regEnable) <= 1), 32'd1);
        check_val("rdest_sel",   32'(rdest_sel),   32'(rd));
        check_val("rsrc_sel",    32'(rsrc_sel),    32'(rs));
        check_val("alu_op",      32'(alu_op),      32'(e_alu));
        check_val("imm_sel",     32'(imm_sel),     32'(e_isel));
        check_val("imm",         32'(imm),         32'(e_imm));
    endtask

    // One clock: advance the model on the edge, then compare 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            if (m_phase == 0) begin
                if (instr_valid) begin
                    m_word  = instr;
                    m_phase = 1;
                    $display("accept instr=%04h at %0t", instr, $time);
                end
            end else begin
                m_phase = (m_phase + 1) % 4;
            end
        end
        #1;
        compare_outputs();
    endtask

    task automatic drive(input logic v, input logic [15:0] w);
        instr_valid = v;
        instr       = w;
    endtask

    // Single instruction, then idle inputs; checks the WB pulses explicitly
    task automatic run_one(input logic [15:0] w, input logic [15:0] exp_re,
                           input logic exp_fw, input logic [15:0] exp_imm);
        drive(1'b1, w);
        tick();
        check_val("dir_imm", 32'(imm), 32'(exp_imm));
        drive(1'b0, 16'($urandom));
        tick();
        tick();
        check_val("dir_regEnable", 32'(regEnable), 32'(exp_re));
        check_val("dir_flags_we",  32'(flags_we),  32'(exp_fw));
        check_val("dir_done",      32'(done),      32'd1);
        tick();
        $display("txn instr=%04h regEnable=%04h flags_we=%0b", w, exp_re, exp_fw);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 16'h0000);
        // Reset held for three cycles; model holds reset values
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Directed cases
        run_one(16'h0351, 16'h0008, 1'b1, 16'h0051);
        run_one(16'h5AF0, 16'h0400, 1'b1, 16'hFFF0);
        run_one(16'h02B4, 16'h0000, 1'b1, 16'hFFB4);
        run_one(16'hF123, 16'h0000, 1'b0, 16'h0023);

        // Back-to-back with valid held; the new word shows up while busy
        drive(1'b1, 16'h0151);
        tick();
        drive(1'b1, 16'h0E51);
        tick();
        tick();
        check_val("b2b_first", 32'(regEnable), 32'h0002);
        tick();
        tick();
        tick();
        tick();
        check_val("b2b_second", 32'(regEnable), 32'h4000);
        drive(1'b0, 16'h0000);
        tick();
        $display("txn back-to-back 0151/0E51 done");

        // Reset asserted during EXEC
        drive(1'b1, 16'h0751);
        tick();
        drive(1'b0, 16'h0000);
        tick();
        #2;
        reset   = 1'b0;
        m_word  = 16'h0000;
        m_phase = 0;
        #1;
        check_val("rst_regEnable", 32'(regEnable),   32'h0);
        check_val("rst_ready",     32'(instr_ready), 32'h1);
        check_val("rst_done",      32'(done),        32'h0);
        compare_outputs();
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 16'h0C42);
        tick();
        check_val("post_rst_accept", 32'(instr_ready), 32'h0);
        drive(1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) tick();
        $display("txn reset during EXEC recovered");

        // Random traffic, biased toward the special opcodes
        for (int i = 0; i < 400; i++) begin
            logic [15:0] w;
            int sel;
            w   = 16'($urandom);
            sel = int'($urandom_range(0, 5));
            if (sel == 0) w[15:12] = 4'h0;
            else if (sel == 1) w[15:12] = 4'hF;
            else if (sel == 2) w[15:12] = 4'hB;
            else if (sel == 3) w[7:4]   = 4'hB;
            drive(($urandom_range(0, 3) != 0), w);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regbank_ctrl.md
# regbank_ctrl

Multi-cycle sequencer for the 16 × 16-bit register bank and its ALU.
- Accepts one 16-bit instruction word per transaction over a valid/ready handshake.
- Decodes the word into operand-select, ALU-function and immediate controls.
- Generates the one-hot 16-bit write enable that commits the ALU bus result to exactly one register.
- Sits between the instruction source (fetch logic or testbench) and the register-bank/ALU datapath; owns all register-write timing.

## Interface
Parameters:
- none (fixed 16 registers, 16-bit words)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- instr  in  16  instruction word: [15:12] op, [11:8] rdest, [7:4] ext, [3:0] rsrc
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  controller can accept an instruction
- rsrc_sel  out  4  read-mux select for operand B register
- rdest_sel  out  4  read-mux select for operand A register (also the write target)
- alu_op  out  4  ALU function code
- imm_sel  out  1  1 = operand B is imm, 0 = operand B is register rsrc
- imm  out  16  sign-extended {ext, rsrc}
- regEnable  out  16  one-hot register write enable
- flags_we  out  1  capture ALU flags this cycle
- done  out  1  one-cycle pulse: instruction retired

## Operation
- States: IDLE, DECODE, EXEC, WB. Encoding: 2-bit binary 00/01/10/11.
- IDLE:
  - instr_ready=1.
  - instr_valid&&instr_ready latches instr into internal IR, then goes to DECODE.
  - Otherwise stays in IDLE.
- DECODE: rdest_sel, rsrc_sel, imm, imm_sel, alu_op driven from IR; then EXEC.
- EXEC: same controls held stable so the ALU bus settles; then WB.
- WB:
  - regEnable = 1<<rdest when writeback is required, else 0.
  - flags_we=1 when the op class sets flags.
  - done=1; then IDLE.
- Decode rules:
  - op=0000 (register form): alu_op=ext, imm_sel=0.
  - op=1111: NOP; alu_op=0000, regEnable stays 0 in WB, flags_we=0.
  - Any other op (immediate form): alu_op=op, imm_sel=1, imm = {{8{ext[3]}}, ext, rsrc}.
- Compare: register-form ext=1011 or immediate op=1011 gives flags_we=1 and no register write.
- Every other non-NOP instruction gives flags_we=1 and a register write.
- Control outputs are valid only in DECODE, EXEC and WB; in IDLE they hold their last value.
- IR is unchanged outside IDLE; instr/instr_valid are ignored while busy (instr_ready=0).

## Timing
- Reset values:
  - state=IDLE, IR=16'h0000.
  - instr_ready=1.
  - regEnable=0, flags_we=0, done=0.
  - alu_op=0, rsrc_sel=0, rdest_sel=0, imm_sel=0, imm=0.
- Accept happens at edge E0. State sequence:
  - DECODE in cycle E0→E1.
  - EXEC in E1→E2.
  - WB in E2→E3; the register updates at E3.
  - IDLE from E3, earliest next accept at E4.
- Throughput: one instruction per 4 cycles.
- regEnable, flags_we and done are high for exactly one cycle, all in WB, and are never asserted together with instr_ready.
- At most one regEnable bit is ever set; regEnable is 0 in every state except WB.
- instr_valid held high continuously: a new instruction is accepted every 4th edge; no instruction is lost or duplicated.
- Reset asserted mid-transaction (any state): outputs go to reset values immediately and combinationally with reset.
  - No partial write occurs; regEnable drops in the same instant.
  - After reset deasserts, the first accept is possible at the next rising edge.
- rdest=0 is a legal write target (no r0 protection).

## Structure
- Package regbank_ctrl_pkg:
  - state enum (IDLE/DECODE/EXEC/WB);
  - OP_RTYPE=4'b0000, OP_NOP=4'b1111, OP_CMP=4'b1011;
  - instruction field bit positions.
- Sub-module reg_sel_decoder: 4-bit index + enable in, 16-bit one-hot out, purely combinational.
  - Instantiated once to drive regEnable from IR[11:8] with enable = (state==WB) && writeback.
- Top level holds the FSM, IR and decode logic.

## Test plan
- Reset then idle: hold reset low 3 cycles, release → instr_ready=1, regEnable=0, done=0 for 10 idle cycles.
- R-type write: instr=16'h0351 with instr_valid for one cycle → DECODE/EXEC show rdest_sel=3, rsrc_sel=1, alu_op=5, imm_sel=0 → WB: regEnable=16'h0008, flags_we=1, done=1 for 1 cycle.
- Immediate sign-extend: instr=16'h5AF0 → imm=16'hFFF0, imm_sel=1, alu_op=5 → WB: regEnable=16'h0400.
- Compare and NOP:
  - instr=16'h02B4 → WB: regEnable=0, flags_we=1.
  - instr=16'hF123 → WB: regEnable=0, flags_we=0, done=1.
- Back-to-back: instr_valid held high with 16'h0151 then 16'h0E51 → accepts spaced 4 cycles apart, regEnable=16'h0002 then 16'h4000, instr change while busy ignored.
- Reset mid-op: assert reset during EXEC of 16'h0751 → regEnable never goes high, state returns to IDLE, instr_ready=1 after release.
